// File: rtl/reg_seq_pkg.sv
// Shared op codes, FSM encoding and op classification helpers for the
// register operation sequencer.
package reg_seq_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_CLR  = 4'd1,
    OP_LOAD = 4'd2,
    OP_INC  = 4'd3,
    OP_DEC  = 4'd4,
    OP_SHR  = 4'd5,
    OP_SHL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_ROL  = 4'd8
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // CLR/LOAD strobe exactly once regardless of the requested count.
  function automatic logic op_single(op_t op);
    return (op == OP_CLR) || (op == OP_LOAD);
  endfunction

  function automatic logic op_counted(op_t op);
    return (op == OP_INC) || (op == OP_DEC) || (op == OP_SHR) ||
           (op == OP_SHL) || (op == OP_ROR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/reg_op_sequencer_if.sv
// Command channel between the control unit (master) and the sequencer (slave).
interface reg_op_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 5
) ();
  import reg_seq_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  op_t                   cmd_op;
  logic [CNT_WIDTH-1:0]  cmd_cnt;
  logic                  cmd_fill;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  abort;

  modport master (
    output cmd_valid, cmd_op, cmd_cnt, cmd_fill, cmd_data, abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, cmd_fill, cmd_data, abort,
    output cmd_ready
  );

endinterface

// File: rtl/reg_op_sequencer.sv
// Drives one register's strobes for N cycles per accepted command, so
// multi-step inc/dec/shift/rotate need no per-step control from the CPU.
module reg_op_sequencer
  import reg_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  reg_op_sequencer_if.slave     cmd,
  input  logic [DATA_WIDTH-1:0] reg_q,
  output logic                  reg_cl,
  output logic                  reg_ld,
  output logic                  reg_inc,
  output logic                  reg_dec,
  output logic                  reg_sr,
  output logic                  reg_sl,
  output logic                  reg_ir,
  output logic                  reg_il,
  output logic [DATA_WIDTH-1:0] reg_in,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);

  state_t                state;
  op_t                   op;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  fill;
  logic [DATA_WIDTH-1:0] data;
  logic                  ready_q, busy_q, done_q, aborted_q;
  logic [CNT_WIDTH-1:0]  reps;

  always_comb begin
    reps = '0;
    if (op_single(cmd.cmd_op))       reps = CNT_WIDTH'(1);
    else if (op_counted(cmd.cmd_op)) reps = cmd.cmd_cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op        <= OP_NOP;
      cnt       <= '0;
      fill      <= 1'b0;
      data      <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd.cmd_valid) begin
            op      <= cmd.cmd_op;
            fill    <= cmd.cmd_fill;
            data    <= cmd.cmd_data;
            cnt     <= reps;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (reps == '0) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              state  <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          cnt <= cnt - CNT_WIDTH'(1);
          if (cnt == CNT_WIDTH'(1) || cmd.abort) begin
            state     <= ST_DONE;
            done_q    <= 1'b1;
            // An abort on the final strobe cycle ends nothing early.
            aborted_q <= (cnt != CNT_WIDTH'(1));
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;

  // Strobes stay combinational so rotates see the current reg_q each cycle.
  always_comb begin
    reg_cl  = 1'b0;
    reg_ld  = 1'b0;
    reg_inc = 1'b0;
    reg_dec = 1'b0;
    reg_sr  = 1'b0;
    reg_sl  = 1'b0;
    reg_ir  = 1'b0;
    reg_il  = 1'b0;
    reg_in  = '0;
    if (state == ST_RUN) begin
      case (op)
        OP_CLR:  reg_cl  = 1'b1;
        OP_LOAD: begin
          reg_ld = 1'b1;
          reg_in = data;
        end
        OP_INC:  reg_inc = 1'b1;
        OP_DEC:  reg_dec = 1'b1;
        OP_SHR:  begin
          reg_sr = 1'b1;
          reg_ir = fill;
        end
        OP_SHL:  begin
          reg_sl = 1'b1;
          reg_il = fill;
        end
        OP_ROR:  begin
          reg_sr = 1'b1;
          reg_ir = reg_q[0];
        end
        OP_ROL:  begin
          reg_sl = 1'b1;
          reg_il = reg_q[DATA_WIDTH-1];
        end
        default: ;
      endcase
    end
  end

endmodule
